scs_link_decoder: RTL and testbench
===================================

Name: scs_link_decoder

Overview:
- Receive-side stage directly downstream of the 32-bit crosstalk-aware bus-invert encoder.
- Accepts encoded link flits through a valid/ready handshake, buffers them, and removes the per-lane inversion. Each byte lane carries 7 payload bits [6:0] and an invert flag in bit 7.
- Delivers decoded flits to the router/core side through a second valid/ready handshake.

Parameters:
- FIFO_DEPTH, 2, decoded-flit buffer entries; power of two, ≥2.
- CNT_W, 16, width of the statistics counters (used only under STATS_EN).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- link_data  in  32  encoded flit. Lane k occupies bits [8k+7:8k]; bit 8k+7 is the invert flag.
- link_valid  in  1  link_data is valid.
- link_ready  out  1  decoder can accept a flit this cycle.
- out_data  out  32  decoded flit.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  consumer accepts out_data.
- inv_flags  out  4  invert flags of the flit currently on out_data; bit k = lane k.
- stat_clr  in  1  clears the statistics counters (STATS_EN only; otherwise ignored).
- stat_inv_cnt  out  4*CNT_W  per-lane inversion counters (STATS_EN only; otherwise driven 0).
- stat_flit_cnt  out  CNT_W  count of accepted flits (STATS_EN only; otherwise driven 0).

Behaviour:
- Lane decode (combinational, applied on push):
  - dec[8k+6:8k] = link_data[8k+6:8k] XOR {7{link_data[8k+7]}}.
  - dec[8k+7] = 0; this bit is reserved and carries no payload.
  - The flag bit itself is never inverted.
- Buffer: a FIFO of FIFO_DEPTH entries. Each entry holds {inv_flags[3:0], dec[31:0]}. The head entry drives out_data and inv_flags.
- Push occurs when link_valid && link_ready. Pop occurs when out_valid && out_ready.
- link_ready = (count != FIFO_DEPTH). It is a function of registered count only; there is no combinational path from out_ready.
- out_valid = (count != 0).
- Latency: a flit accepted in cycle N is presented on out_data in cycle N+1 when the FIFO was empty. No bypass path.
- Simultaneous push and pop:
  - With 0 < count < FIFO_DEPTH: count is unchanged, both pointers advance, and order is preserved.
  - With count = 0: only the push happens; the pop cannot occur because out_valid = 0.
  - With count = FIFO_DEPTH: only the pop happens; the push cannot occur because link_ready = 0. link_ready rises in the next cycle.
- Pointers wrap modulo FIFO_DEPTH. count is log2(FIFO_DEPTH)+1 bits wide.
- If link_valid drops without a handshake, no state changes. Data held under backpressure must remain stable at out_data until popped.
- Reset (synchronous, active-high):
  - count = 0, pointers = 0.
  - out_valid = 0, link_ready = 1 in the cycle after rst is released.
  - out_data = 0, inv_flags = 0.
  - All statistics counters = 0.
  - Reset asserted mid-transfer discards all buffered flits. A handshake in the same cycle as rst is ignored.
  - While rst is high, link_ready = 0.

Optional Feature:
- Macro: SCS_LINK_DEC_STATS_EN.
- When defined:
  - On each push, stat_flit_cnt increments by 1 and each stat_inv_cnt lane k increments by link_data[8k+7].
  - All counters saturate at 2^CNT_W-1.
  - stat_clr zeroes all counters. If stat_clr and a push occur in the same cycle, the clear wins and the counters become 0.
- When undefined: no counter registers exist, the stat outputs are tied to 0, and stat_clr is unused.

Decomposition:
- Package scs_link_pkg holds:
  - FLIT_W = 32, LANE_W = 8, NUM_LANES = 4, INV_BIT = 7;
  - a flit typedef and a lane typedef.
- The encoder shares this package.
- Sub-module dec_module: one byte-lane combinational decode (8-bit in, 8-bit out, 1-bit flag). Instantiated NUM_LANES times, mirroring the encoder's per-lane structure.
- FIFO and counters live in the top module.

Test Plan:
- Basic decode: push link_data=0x85_00_FF_7F with out_ready=1 → next cycle out_valid=1, out_data=0x7A00007F, inv_flags=4'b1010.
- Fill/backpressure: out_ready=0, push 0x01010101 then 0x82828282 → link_ready=0 after the second push. A third flit held on link_data is not accepted. Then out_ready=1 → outputs 0x01010101, then 0x7D7D7D7D, in order; link_ready returns to 1.
- Simultaneous push/pop at count=1: hold link_valid=1 and out_ready=1 with a streaming sequence 0x00000001,0x00000002,0x00000003 → count stays 1, outputs follow one cycle later with no bubbles or drops.
- Reset mid-operation: buffer 2 flits, assert rst for 1 cycle → out_valid=0 and count=0; link_ready=1 after release; the previously buffered flits never appear.
- STATS_EN: push 0x80000080, then 0x80808080, then 0x00000000 → stat_flit_cnt=3, stat_inv_cnt lanes[3:0]={2,1,1,2}. Assert stat_clr together with a fourth push → all counters 0.
- STATS_EN saturation: with CNT_W=4, push 20 flits all with flag bits set → every counter holds 15.

Source files
------------

// File: rtl/scs_link_pkg.sv
// Shared link-flit definitions for the bus-invert encoder and decoder.
// Each byte lane carries 7 payload bits plus an invert flag in the MSB.
package scs_link_pkg;
    localparam int FLIT_W    = 32;
    localparam int LANE_W    = 8;
    localparam int NUM_LANES = 4;
    localparam int INV_BIT   = 7;

    typedef logic [FLIT_W-1:0] flit_t;
    typedef logic [LANE_W-1:0] lane_t;

    typedef struct packed {
        logic [NUM_LANES-1:0] inv;
        flit_t                dat;
    } fifo_entry_t;
endpackage

// File: rtl/scs_link_decoder_dec.sv
// Single byte-lane bus-invert decode: un-invert the payload, clear the flag position.
// Purely combinational; the flag is reported separately and never inverted.
module dec_module
    import scs_link_pkg::*;
(
    input  lane_t lane_i,
    output lane_t lane_o,
    output logic  inv_o
);
    assign inv_o  = lane_i[INV_BIT];
    assign lane_o = {1'b0, lane_i[INV_BIT-1:0] ^ {INV_BIT{lane_i[INV_BIT]}}};
endmodule

// File: rtl/scs_link_decoder.sv
// Link receive decoder: per-lane invert removal into a FIFO_DEPTH flit buffer, one-cycle latency.
// Optional statistics counters are built only when SCS_LINK_DEC_STATS_EN is defined.
module scs_link_decoder
    import scs_link_pkg::*;
#(
    parameter int FIFO_DEPTH = 2,
    parameter int CNT_W      = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [FLIT_W-1:0]          link_data,
    input  logic                       link_valid,
    output logic                       link_ready,
    output logic [FLIT_W-1:0]          out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [NUM_LANES-1:0]       inv_flags,
    input  logic                       stat_clr,
    output logic [NUM_LANES*CNT_W-1:0] stat_inv_cnt,
    output logic [CNT_W-1:0]           stat_flit_cnt
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_B = PTR_W + 1;

    flit_t                dec_flit;
    logic [NUM_LANES-1:0] dec_inv;

    for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
        dec_module u_dec (
            .lane_i (link_data[k*LANE_W +: LANE_W]),
            .lane_o (dec_flit[k*LANE_W +: LANE_W]),
            .inv_o  (dec_inv[k])
        );
    end

    fifo_entry_t      mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_B-1:0] count_q, count_d;
    logic             push, pop;
    fifo_entry_t      head;

    // link_ready depends only on registered count (and reset), never on out_ready.
    assign link_ready = !rst && (count_q != CNT_B'(FIFO_DEPTH));
    assign out_valid  = (count_q != '0);
    assign push       = link_valid && link_ready;
    assign pop        = out_valid && out_ready;
    assign head       = mem_q[rd_ptr_q];
    assign out_data   = out_valid ? head.dat : '0;
    assign inv_flags  = out_valid ? head.inv : '0;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: outputs are masked while the buffer is empty.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= '{inv: dec_inv, dat: dec_flit};
    end

`ifdef SCS_LINK_DEC_STATS_EN
    logic [CNT_W-1:0]                  flit_cnt_q, flit_cnt_d;
    logic [NUM_LANES-1:0][CNT_W-1:0]   inv_cnt_q, inv_cnt_d;

    always_comb begin
        flit_cnt_d = flit_cnt_q;
        inv_cnt_d  = inv_cnt_q;
        if (stat_clr) begin
            flit_cnt_d = '0;
            inv_cnt_d  = '0;
        end else if (push) begin
            if (flit_cnt_q != '1) flit_cnt_d = flit_cnt_q + 1'b1;
            for (int k = 0; k < NUM_LANES; k++) begin
                if (dec_inv[k] && inv_cnt_q[k] != '1) inv_cnt_d[k] = inv_cnt_q[k] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            flit_cnt_q <= '0;
            inv_cnt_q  <= '0;
        end else begin
            flit_cnt_q <= flit_cnt_d;
            inv_cnt_q  <= inv_cnt_d;
        end
    end

    assign stat_flit_cnt = flit_cnt_q;
    assign stat_inv_cnt  = inv_cnt_q;
`else
    logic unused_stat_clr;
    assign unused_stat_clr = stat_clr;
    assign stat_flit_cnt   = '0;
    assign stat_inv_cnt    = '0;
`endif
endmodule

// File: tb/tb_scs_link_decoder.sv
// Directed bench for scs_link_decoder with a queue-based reference model checked every cycle.
module tb_scs_link_decoder;
    localparam int DEPTH = 2;
    localparam int CW    = 4;
    localparam int SAT   = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic [31:0]   link_data;
    logic          link_valid;
    logic          link_ready;
    logic [31:0]   out_data;
    logic          out_valid;
    logic          out_ready;
    logic [3:0]    inv_flags;
    logic          stat_clr;
    logic [4*CW-1:0] stat_inv_cnt;
    logic [CW-1:0] stat_flit_cnt;

    int checks = 0;
    int errors = 0;

    scs_link_decoder #(.FIFO_DEPTH(DEPTH), .CNT_W(CW)) dut (
        .clk           (clk),
        .rst           (rst),
        .link_data     (link_data),
        .link_valid    (link_valid),
        .link_ready    (link_ready),
        .out_data      (out_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .inv_flags     (inv_flags),
        .stat_clr      (stat_clr),
        .stat_inv_cnt  (stat_inv_cnt),
        .stat_flit_cnt (stat_flit_cnt)
    );

    always #5 clk = ~clk;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // Reference: payload of a flagged lane is the complement of its low 7 bits.
    function automatic logic [31:0] decode(logic [31:0] d);
        logic [31:0] r;
        for (int k = 0; k < 4; k++) begin
            logic [7:0] b;
            b = d[8*k +: 8];
            r[8*k +: 8] = b[7] ? {1'b0, ~b[6:0]} : {1'b0, b[6:0]};
        end
        return r;
    endfunction

    function automatic logic [3:0] flags_of(logic [31:0] d);
        return {d[31], d[23], d[15], d[7]};
    endfunction

    logic [31:0] mq[$];
    logic [3:0]  fq[$];
    int          m_flit;
    int          m_inv[4];
    bit          started = 0;

    always @(posedge clk) begin
        bit push, pop;
        started = 1;
        if (rst) begin
            mq.delete();
            fq.delete();
            m_flit = 0;
            for (int k = 0; k < 4; k++) m_inv[k] = 0;
        end else begin
            pop  = out_ready && (mq.size() > 0);
            push = link_valid && (mq.size() < DEPTH);
            if (pop) begin
                void'(mq.pop_front());
                void'(fq.pop_front());
            end
            if (push) begin
                mq.push_back(decode(link_data));
                fq.push_back(flags_of(link_data));
            end
            if (stat_clr) begin
                m_flit = 0;
                for (int k = 0; k < 4; k++) m_inv[k] = 0;
            end else if (push) begin
                if (m_flit < SAT) m_flit++;
                for (int k = 0; k < 4; k++)
                    if (link_data[8*k+7] && m_inv[k] < SAT) m_inv[k]++;
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            logic [4*CW-1:0] e_inv;
            chk("out_valid", 32'(out_valid), 32'(mq.size() != 0));
            chk("link_ready", 32'(link_ready), 32'(!rst && mq.size() < DEPTH));
            chk("out_data", out_data, (mq.size() != 0) ? mq[0] : 32'h0);
            chk("inv_flags", 32'(inv_flags), (fq.size() != 0) ? 32'(fq[0]) : 32'h0);
`ifdef SCS_LINK_DEC_STATS_EN
            for (int k = 0; k < 4; k++) e_inv[k*CW +: CW] = CW'(m_inv[k]);
            chk("stat_flit_cnt", 32'(stat_flit_cnt), 32'(m_flit));
            chk("stat_inv_cnt", 32'(stat_inv_cnt), 32'(e_inv));
`else
            e_inv = '0;
            chk("stat_flit_cnt", 32'(stat_flit_cnt), 32'h0);
            chk("stat_inv_cnt", 32'(stat_inv_cnt), 32'(e_inv));
`endif
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1; link_data = '0; link_valid = 0; out_ready = 0; stat_clr = 0;
        step(); step();
        chk("rst_link_ready_low", 32'(link_ready), 32'h0);
        rst = 0;
        #1;
        chk("rel_link_ready", 32'(link_ready), 32'h1);
        chk("rel_out_valid", 32'(out_valid), 32'h0);
        chk("rel_out_data", out_data, 32'h0);

        // Basic decode
        link_data = 32'h8500FF7F; link_valid = 1; out_ready = 1;
        step();
        link_valid = 0;
        chk("basic_valid", 32'(out_valid), 32'h1);
        chk("basic_data", out_data, 32'h7A00007F);
        chk("basic_flags", 32'(inv_flags), 32'hA);
        step();

        // Fill and backpressure
        out_ready = 0;
        link_data = 32'h01010101; link_valid = 1;
        step();
        link_data = 32'h82828282;
        step();
        chk("full_link_ready", 32'(link_ready), 32'h0);
        link_data = 32'h12345678;
        step(); step();
        chk("held_data", out_data, 32'h01010101);
        link_valid = 0; out_ready = 1;
        step();
        chk("order_second", out_data, 32'h7D7D7D7D);
        chk("ready_back", 32'(link_ready), 32'h1);
        step();
        chk("drained", 32'(out_valid), 32'h0);

        // Streaming push/pop at count 1
        out_ready = 1; link_valid = 1;
        for (int i = 1; i <= 3; i++) begin
            link_data = 32'(i);
            step();
            chk("stream_data", out_data, 32'(i));
        end
        link_valid = 0;
        step(); step();

        // Reset mid-operation discards buffered flits
        out_ready = 0; link_valid = 1;
        link_data = 32'hAAAAAAAA; step();
        link_data = 32'h55555555; step();
        rst = 1;
        step();
        chk("midrst_valid", 32'(out_valid), 32'h0);
        rst = 0; link_valid = 0; out_ready = 1;
        #1;
        chk("midrst_ready", 32'(link_ready), 32'h1);
        step(); step();

        // Statistics
        stat_clr = 1; step(); stat_clr = 0;
        link_valid = 1;
        link_data = 32'h80000080; step();
        link_data = 32'h80808080; step();
        link_data = 32'h00000000; step();
        link_valid = 0;
`ifdef SCS_LINK_DEC_STATS_EN
        chk("stats_flit3", 32'(stat_flit_cnt), 32'd3);
        chk("stats_inv", 32'(stat_inv_cnt), 32'h2112);
`endif
        link_valid = 1; stat_clr = 1; link_data = 32'h80808080;
        step();
        link_valid = 0; stat_clr = 0;
        chk("stats_clr_flit", 32'(stat_flit_cnt), 32'h0);
        chk("stats_clr_inv", 32'(stat_inv_cnt), 32'h0);
        step();

        // Saturation
        link_valid = 1; link_data = 32'h80808080;
        for (int i = 0; i < 20; i++) step();
        link_valid = 0;
`ifdef SCS_LINK_DEC_STATS_EN
        chk("sat_flit", 32'(stat_flit_cnt), 32'hF);
        chk("sat_inv", 32'(stat_inv_cnt), 32'hFFFF);
`endif
        step(); step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
